// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage hazard unit (load-use stall, branch flush, memory-wait freeze, timeout halt); in: clk rst_n id_rs id_rt id_uses_rt ex_mem_read ex_rt branch_taken mem_req mem_ready; out: pc/ifid/idex/exmem/memwb_en ifid/idex/exmem_flush stall_count flush_count state halted
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state,
  output logic             halted
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;
  localparam int WW = $clog2(TIMEOUT + 1) < 1 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(TIMEOUT);
  state_t st;
  logic [WW-1:0] wait_cnt;
  logic br_pend, load_use, br_eff, active, do_flush, do_stall;
  always_comb begin
    load_use = ex_mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    br_eff = branch_taken || (st == MEM_WAIT && br_pend);
    active = (st == RUN && !(mem_req && !mem_ready)) || (st == MEM_WAIT && mem_ready);
    do_flush = active && br_eff;
    do_stall = active && !br_eff && load_use;
  end
  assign pc_en = !rst_n || (active && !do_stall);
  assign ifid_en = pc_en;
  assign idex_en = !rst_n || active;
  assign exmem_en = idex_en;
  assign memwb_en = idex_en;
  assign ifid_flush = rst_n && do_flush;
  assign idex_flush = rst_n && (do_flush || do_stall);
  assign exmem_flush = ifid_flush;
  assign state = st;
  assign halted = st == HALT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= RUN;
      wait_cnt <= '0;
      br_pend <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (do_stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (do_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      if (st == RUN && mem_req && !mem_ready) begin
        st <= MEM_WAIT;
        wait_cnt <= WW'(1);
        br_pend <= branch_taken;
      end else if (st == MEM_WAIT && mem_ready) begin
        st <= RUN;
        br_pend <= 1'b0;
      end else if (st == MEM_WAIT) begin
        br_pend <= br_pend || branch_taken;
        if (wait_cnt == TO) st <= HALT;
        else wait_cnt <= wait_cnt + WW'(1);
      end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a cycle-level reference model of the hazard rules
module tb_pipe_hazard_ctrl;
  localparam int TO = 4, CW = 4, MAXC = (1 << CW) - 1;
  logic clk = 0, rst_n = 0;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic id_uses_rt = 0, ex_mem_read = 0, branch_taken = 0, mem_req = 0, mem_ready = 1;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halted;
  logic [CW-1:0] stall_count, flush_count;
  logic [1:0] state;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_waits = 0, m_stalls = 0, m_flushes = 0;
  bit m_pend = 0;
  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .stall_count(stall_count),
    .flush_count(flush_count), .state(state), .halted(halted)
  );
  always #5 clk = ~clk;
  wire [7:0] ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask
  function automatic bit lu();
    return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction
  function automatic logic [7:0] exp_ctl();
    if (!rst_n) return 8'hF8;
    if (m_mode == 2 || (m_mode == 0 && mem_req && !mem_ready) || (m_mode == 1 && !mem_ready)) return 8'h00;
    if (branch_taken || (m_mode == 1 && m_pend)) return 8'hFF;
    if (lu()) return 8'h3A;
    return 8'hF8;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_mode = 0; m_waits = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_mode == 0 && mem_req && !mem_ready) begin
      m_mode = 1; m_waits = 1; m_pend = branch_taken;
    end else if (m_mode == 1 && !mem_ready) begin
      m_pend = m_pend | branch_taken;
      if (m_waits == TO) m_mode = 2;
      else m_waits++;
    end else if (m_mode != 2) begin
      if (branch_taken || m_pend) begin
        if (m_flushes < MAXC) m_flushes++;
      end else if (lu() && m_stalls < MAXC) m_stalls++;
      m_pend = 0;
      m_mode = 0;
    end
  always @(negedge clk) begin
    chk("ctl", ctl, exp_ctl());
    chk("state", state, m_mode);
    chk("halted", halted, m_mode == 2);
    chk("stall_count", stall_count, m_stalls);
    chk("flush_count", flush_count, m_flushes);
  end
  task automatic set(input logic [4:0] rs, rt, input logic urt, mr, input logic [4:0] ert,
                     input logic br, mq, rdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr; ex_rt = ert;
    branch_taken = br; mem_req = mq; mem_ready = rdy;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_state", state, 0);
    chk("rst_ctl", ctl, 8'hF8);
    chk("rst_stall", stall_count, 0);
    rst_n = 1;
    set(5, 0, 0, 1, 5, 0, 0, 1); #1;
    chk("lu_ctl", ctl, 8'h3A);
    tick();
    chk("lu_stall", stall_count, 1);
    set(0, 0, 0, 1, 0, 0, 0, 1); #1;
    chk("rt0_ctl", ctl, 8'hF8);
    tick();
    chk("rt0_stall", stall_count, 1);
    set(1, 7, 1, 1, 7, 0, 0, 1); tick();
    chk("urt_stall", stall_count, 2);
    set(1, 7, 0, 1, 7, 0, 0, 1); tick();
    chk("nurt_stall", stall_count, 2);
    set(5, 0, 0, 1, 5, 1, 0, 1); #1;
    chk("br_lu_ctl", ctl, 8'hFF);
    tick();
    chk("br_flush", flush_count, 1);
    chk("br_stall", stall_count, 2);
    set(0, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("mw_ctl0", ctl, 8'h00);
    tick();
    chk("mw_state", state, 1);
    tick(); tick();
    chk("mw_state3", state, 1);
    set(0, 0, 0, 0, 0, 0, 1, 1); #1;
    chk("mw_ready_ctl", ctl, 8'hF8);
    tick();
    chk("mw_run", state, 0);
    set(0, 0, 0, 0, 0, 0, 1, 0); tick();
    set(0, 0, 0, 0, 0, 1, 1, 0); tick();
    set(0, 0, 0, 0, 0, 0, 1, 0); tick();
    set(0, 0, 0, 0, 0, 0, 1, 1); #1;
    chk("defer_ctl", ctl, 8'hFF);
    tick();
    chk("defer_flush", flush_count, 2);
    set(0, 0, 0, 0, 0, 0, 0, 1); #1;
    chk("pend_clear_ctl", ctl, 8'hF8);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    chk("to_wait", state, 1);
    tick();
    chk("to_halt", state, 2);
    chk("to_halted", halted, 1);
    set(0, 0, 0, 0, 0, 0, 1, 1); #1;
    chk("halt_ctl", ctl, 8'h00);
    tick();
    chk("halt_stays", state, 2);
    rst_n = 0; #1;
    chk("rst_abort_state", state, 0);
    chk("rst_abort_flush", flush_count, 0);
    chk("rst_abort_ctl", ctl, 8'hF8);
    tick();
    rst_n = 1;
    set(9, 0, 0, 1, 9, 0, 0, 1);
    repeat (20) tick();
    chk("sat_stall", stall_count, 15);
    set(0, 0, 0, 0, 0, 1, 0, 1);
    repeat (17) tick();
    chk("sat_flush", flush_count, 15);
    set(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
